stim_pulse_responder: RTL

Responder end of the closed-loop discriminator handshake. It accepts the one-sample stimulation request raised by the window-discriminator FSM when it reaches its stim state, and produces a timed stimulation pulse train: delay, width, period and count. It then enforces a refractory hold-off and reports acceptance, completion and dropped requests back to host registers. It runs in the sample-rate domain beside the DAC channels and the discriminator.

---
 rtl/stim_pulse_responder.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/stim_pulse_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stim_pulse_responder: accepts a discriminator stim request and plays a   |
// | delay/width/period/count pulse train followed by a refractory hold-off.  |
// | Optional STIM_BLANK_EN: blank output with a latched post-done tail.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module stim_pulse_responder #(
   parameter int CNT_W = 16,
   parameter int NP_W  = 8
) (
   input  logic             sample_CLK_out,
   input  logic             reset,
   input  logic             stim_req,
   input  logic             enable,
   input  logic [CNT_W-1:0] delay_cnt,
   input  logic [CNT_W-1:0] pulse_width,
   input  logic [CNT_W-1:0] pulse_period,
   input  logic [NP_W-1:0]  pulse_count,
   input  logic [CNT_W-1:0] refractory,
   input  logic [7:0]       blank_tail,
   output logic             stim_out,
   output logic             busy,
   output logic             ack,
   output logic             done,
   output logic [CNT_W-1:0] dropped_cnt,
   output logic [2:0]       state,
   output logic             blank
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DELAY    = 3'd1,
      S_PULSE_HI = 3'd2,
      S_PULSE_LO = 3'd3,
      S_REFRACT  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_CNT_ONES = '1;
   localparam logic [NP_W-1:0]  C_NP_ONE   = NP_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NP_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] refr_q, refr_d;
   logic [CNT_W-1:0] dropped_q, dropped_d;
   logic             stim_q, stim_d;
   logic             busy_q, busy_d;
   logic             ack_q, ack_d;
   logic             done_q, done_d;

   logic [CNT_W-1:0] w_width;
   logic [CNT_W-1:0] w_period;
   logic             w_enter_refr;
   logic             w_finish;

   // Clamp request fields; an all-ones width cannot grow by one, so the
   // period saturates there instead of wrapping.
   always_comb begin
      w_width  = (pulse_width == '0) ? C_CNT_ONE : pulse_width;
      w_period = pulse_period;
      if (w_width == C_CNT_ONES) begin
         w_period = C_CNT_ONES;
      end else if (pulse_period <= w_width) begin
         w_period = w_width + C_CNT_ONE;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      width_d      = width_q;
      gap_d        = gap_q;
      refr_d       = refr_q;
      dropped_d    = dropped_q;
      stim_d       = 1'b0;
      busy_d       = busy_q;
      ack_d        = 1'b0;
      done_d       = 1'b0;
      w_enter_refr = 1'b0;
      w_finish     = 1'b0;

      if ((state_q != S_IDLE) && stim_req && (dropped_q != C_CNT_ONES)) begin
         dropped_d = dropped_q + C_CNT_ONE;
      end

      // cnt holds the number of further edges to spend in the current state
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (stim_req && enable) begin
               ack_d   = 1'b1;
               busy_d  = 1'b1;
               width_d = w_width;
               gap_d   = w_period - w_width;
               refr_d  = refractory;
               rem_d   = (pulse_count == '0) ? '0 : pulse_count - C_NP_ONE;
               if (delay_cnt == '0) begin
                  state_d = S_PULSE_HI;
                  stim_d  = 1'b1;
                  cnt_d   = w_width - C_CNT_ONE;
               end else begin
                  state_d = S_DELAY;
                  cnt_d   = delay_cnt - C_CNT_ONE;
               end
            end
         end
         S_DELAY: begin
            if (!enable) begin
               w_enter_refr = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = S_PULSE_HI;
               stim_d  = 1'b1;
               cnt_d   = width_q - C_CNT_ONE;
            end else begin
               cnt_d = cnt_q - C_CNT_ONE;
            end
         end
         S_PULSE_HI: begin
            if (!enable) begin
               w_enter_refr = 1'b1;
            end else if (cnt_q != '0) begin
               stim_d = 1'b1;
               cnt_d  = cnt_q - C_CNT_ONE;
            end else if (rem_q == '0) begin
               w_enter_refr = 1'b1;
            end else if (gap_q == '0) begin
               stim_d = 1'b1;
               cnt_d  = width_q - C_CNT_ONE;
               rem_d  = rem_q - C_NP_ONE;
            end else begin
               state_d = S_PULSE_LO;
               cnt_d   = gap_q - C_CNT_ONE;
            end
         end
         S_PULSE_LO: begin
            if (!enable) begin
               w_enter_refr = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = S_PULSE_HI;
               stim_d  = 1'b1;
               cnt_d   = width_q - C_CNT_ONE;
               rem_d   = rem_q - C_NP_ONE;
            end else begin
               cnt_d = cnt_q - C_CNT_ONE;
            end
         end
         S_REFRACT: begin
            if (cnt_q == '0) begin
               w_finish = 1'b1;
            end else begin
               cnt_d = cnt_q - C_CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (w_enter_refr) begin
         if (refr_q == '0) begin
            w_finish = 1'b1;
         end else begin
            state_d = S_REFRACT;
            cnt_d   = refr_q - C_CNT_ONE;
         end
      end

      if (w_finish) begin
         state_d = S_IDLE;
         done_d  = 1'b1;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge sample_CLK_out) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         width_q   <= '0;
         gap_q     <= '0;
         refr_q    <= '0;
         dropped_q <= '0;
         stim_q    <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         width_q   <= width_d;
         gap_q     <= gap_d;
         refr_q    <= refr_d;
         dropped_q <= dropped_d;
         stim_q    <= stim_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
      end
   end

`ifdef STIM_BLANK_EN
   logic [7:0] tail_q, tail_d;
   logic [7:0] tail_cnt_q, tail_cnt_d;
   logic       blank_q, blank_d;

   // Blank covers the whole busy window, then stretches by the latched tail.
   always_comb begin
      tail_d     = tail_q;
      tail_cnt_d = tail_cnt_q;
      blank_d    = blank_q;
      if (ack_d) begin
         blank_d = 1'b1;
         tail_d  = blank_tail;
      end else if (done_d) begin
         blank_d    = (tail_q != 8'd0);
         tail_cnt_d = tail_q - 8'd1;
      end else if (state_q == S_IDLE) begin
         if (blank_q) begin
            if (tail_cnt_q == 8'd0) begin
               blank_d = 1'b0;
            end else begin
               tail_cnt_d = tail_cnt_q - 8'd1;
            end
         end
      end else if (!busy_d) begin
         blank_d = 1'b0;
      end
   end

   always_ff @(posedge sample_CLK_out) begin
      if (reset) begin
         tail_q     <= 8'd0;
         tail_cnt_q <= 8'd0;
         blank_q    <= 1'b0;
      end else begin
         tail_q     <= tail_d;
         tail_cnt_q <= tail_cnt_d;
         blank_q    <= blank_d;
      end
   end

   assign blank = blank_q;
`else
   logic w_unused_blank_tail;
   assign w_unused_blank_tail = ^blank_tail;
   assign blank = 1'b0;
`endif

   assign stim_out    = stim_q;
   assign busy        = busy_q;
   assign ack         = ack_q;
   assign done        = done_q;
   assign dropped_cnt = dropped_q;
   assign state       = state_q;

endmodule
`default_nettype wire
